dmem_store_buffer: RTL and testbench
====================================

DMEM_STORE_BUFFER -- requirements
Module: dmem_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, store-buffer entries; legal values 2, 4, 8.
REQ-002 SHALL have parameter AW, default 30, word-address width.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-005 RST  input  1  asynchronous active-high reset.
REQ-006 DREQ  input  1  core data request, valid for one cycle per access.
REQ-007 DRW  input  1  1 = store, 0 = load; sampled only when DREQ=1.
REQ-008 DADDR  input  AW  core word address.
REQ-009 DWDATA  input  32  core store data.
REQ-010 DRDATA  output  32  load data, valid the cycle after the load request.
REQ-011 MRE  output  1  memory read-port enable.
REQ-012 MRADDR  output  AW  memory read address.
REQ-013 MRDATA  input  32  memory read data, synchronous, one cycle after MRE.
REQ-014 MWE  output  1  memory write-port request.
REQ-015 MWADDR  output  AW  memory write address.
REQ-016 MWDATA  output  32  memory write data.
REQ-017 MWRDY  input  1  write accepted this cycle when MWE=1 and MWRDY=1.
REQ-018 FULL  output  1  buffer holds DEPTH entries.
REQ-019 OVF  output  1  sticky overflow error flag.

Function
REQ-020 SHALL implement an in-order FIFO of DEPTH {addr, data} entries with head/tail pointers wrapping modulo DEPTH and a 0..DEPTH occupancy count.
REQ-021 Store (DREQ=1, DRW=1) SHALL enqueue {DADDR, DWDATA} at the tail on that edge; the entry is visible to forwarding from the next cycle.
REQ-022 MWE SHALL be 1 whenever count>0; MWADDR/MWDATA SHALL equal the head entry; a pop SHALL occur on an edge with MWE=1 and MWRDY=1.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; this is legal at count=DEPTH.
REQ-024 Store with count=DEPTH and no pop that cycle SHALL be dropped, leave the FIFO unchanged, and set OVF=1 until reset.
REQ-025 Load (DREQ=1, DRW=0) SHALL drive MRE=1 and MRADDR=DADDR combinationally in the same cycle; otherwise MRE=0.
REQ-026 In the load cycle, DADDR SHALL be compared with all valid entries, including a head entry being popped that cycle; on a hit, the youngest matching entry's data SHALL be latched.
REQ-027 In the cycle after a load, DRDATA SHALL equal the latched entry data on a hit, else MRDATA.
REQ-028 DRDATA SHALL be 0 in any cycle not following a load.
REQ-029 Loads SHALL NOT stall or reorder the write drain; read and write ports operate independently every cycle.
REQ-030 FULL SHALL equal (count==DEPTH) as a registered-state decode with no combinational path from DREQ.
REQ-031 Latency: store to MWE is 1 cycle when empty; load to DRDATA is 1 cycle, with or without a forwarding hit.
REQ-032 Back-to-back loads every cycle SHALL each return correct data one cycle later.

Reset
REQ-033 While RST=1: count=0, head=tail=0, OVF=0, FULL=0, MWE=0, the load-pending flag is cleared (DRDATA=0), and entry contents are don't-care.
REQ-034 RST asserted mid-drain SHALL discard all buffered stores; no MWE may occur in the first cycle after RST deasserts.
REQ-035 A load issued in the cycle RST deasserts SHALL complete normally.

Verification
REQ-036 Store A=0x10/D=0x11111111 with MWRDY=1 -> MWE=1, MWADDR=0x10 next cycle; popped on that edge; count returns to 0.
REQ-037 MWRDY=0; store 0x20/0xAAAA0000, then 0x20/0xBBBB0000; load 0x20 with MRDATA=0xDEADBEEF -> DRDATA=0xBBBB0000 one cycle later.
REQ-038 MWRDY=0; 4 stores -> FULL=1; 5th store -> OVF=1, count stays 4; raise MWRDY -> 4 writes drain in order, OVF remains 1.
REQ-039 FULL with MWRDY=1 and a new store in the same cycle -> accepted, FULL stays 1, OVF stays 0.
REQ-040 Load of an address not buffered, MRDATA=0x12345678 -> DRDATA=0x12345678; following idle cycle -> DRDATA=0.
REQ-041 RST pulse with 3 entries pending -> MWE=0, FULL=0, OVF=0 immediately; no residual writes after release.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// ---------------------------------------------------------------------------
// dmem_store_buffer
//   In-order store buffer between a core data port and a memory with
//   independent read and write ports. Stores are queued in a DEPTH-entry FIFO
//   and drained through the write port whenever MWRDY accepts them. Loads go
//   straight to the read port. A load that hits a buffered store returns the
//   data of the youngest matching entry instead of MRDATA.
//
// Ports
//   CLK, RST          clock; asynchronous active-high reset
//   DREQ/DRW          core access strobe; 1 = store, 0 = load
//   DADDR/DWDATA      core word address / store data
//   DRDATA            load data, valid the cycle after the load (0 otherwise)
//   MRE/MRADDR/MRDATA memory read port (MRDATA one cycle after MRE)
//   MWE/MWADDR/MWDATA memory write port, head of FIFO; MWRDY accepts
//   FULL              buffer holds DEPTH entries
//   OVF               sticky overflow flag (store dropped while full)
// ---------------------------------------------------------------------------
module dmem_store_buffer #(
    parameter int unsigned DEPTH = 4,   // 2, 4 or 8
    parameter int unsigned AW    = 30
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          DREQ,
    input  logic          DRW,
    input  logic [AW-1:0] DADDR,
    input  logic [31:0]   DWDATA,
    output logic [31:0]   DRDATA,
    output logic          MRE,
    output logic [AW-1:0] MRADDR,
    input  logic [31:0]   MRDATA,
    output logic          MWE,
    output logic [AW-1:0] MWADDR,
    output logic [31:0]   MWDATA,
    input  logic          MWRDY,
    output logic          FULL,
    output logic          OVF
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0] addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          ld_pend_q, ld_pend_d;
    logic          fwd_hit_q, fwd_hit_d;
    logic [31:0]   fwd_data_q, fwd_data_d;

    logic          full;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          load;
    logic          fwd_hit;
    logic [31:0]   fwd_data;

    assign full     = (count_q == CW'(DEPTH));
    assign pop      = (count_q != '0) && MWRDY;
    assign push_req = DREQ && DRW;
    // A full buffer still accepts a store when the head drains on the same edge.
    assign push     = push_req && (!full || pop);
    assign load     = DREQ && !DRW;

    assign MRE    = load;
    assign MRADDR = DADDR;
    assign MWE    = (count_q != '0);
    assign MWADDR = addr_q[head_q];
    assign MWDATA = data_q[head_q];
    assign FULL   = full;
    assign OVF    = ovf_q;
    assign DRDATA = ld_pend_q ? (fwd_hit_q ? fwd_data_q : MRDATA) : '0;

    // Walk entries oldest to youngest so the last match wins. The head entry is
    // included even when it is being popped this cycle.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (addr_q[head_q + PW'(i)] == DADDR)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[head_q + PW'(i)];
            end
        end
    end

    always_comb begin
        head_d     = pop  ? head_q + PW'(1) : head_q;
        tail_d     = push ? tail_q + PW'(1) : tail_q;
        count_d    = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d      = ovf_q || (push_req && full && !pop);
        ld_pend_d  = load;
        fwd_hit_d  = load && fwd_hit;
        fwd_data_d = fwd_data;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            ld_pend_q  <= 1'b0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            ld_pend_q  <= ld_pend_d;
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // Entry storage carries no reset; contents are only meaningful below count.
    always_ff @(posedge CLK) begin
        if (push) begin
            addr_q[tail_q] <= DADDR;
            data_q[tail_q] <= DWDATA;
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_dmem_store_buffer
//   Directed bench for dmem_store_buffer. Inputs are driven on the falling
//   edge; outputs are checked 1 ns later. A queue models the buffered stores
//   (expected write-port traffic) and a second queue holds the expected
//   DRDATA for the following cycle.
// ---------------------------------------------------------------------------
module tb_dmem_store_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 30;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          DREQ = 1'b0;
    logic          DRW = 1'b0;
    logic [AW-1:0] DADDR = '0;
    logic [31:0]   DWDATA = '0;
    logic [31:0]   DRDATA;
    logic          MRE;
    logic [AW-1:0] MRADDR;
    logic [31:0]   MRDATA = '0;
    logic          MWE;
    logic [AW-1:0] MWADDR;
    logic [31:0]   MWDATA;
    logic          MWRDY = 1'b0;
    logic          FULL;
    logic          OVF;

    always #5 CLK = ~CLK;

    dmem_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR),
        .DWDATA(DWDATA), .DRDATA(DRDATA), .MRE(MRE), .MRADDR(MRADDR),
        .MRDATA(MRDATA), .MWE(MWE), .MWADDR(MWADDR), .MWDATA(MWDATA),
        .MWRDY(MWRDY), .FULL(FULL), .OVF(OVF)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } ent_t;

    typedef struct packed {
        logic        v;
        logic        hit;
        logic [31:0] d;
    } rd_t;

    ent_t model[$];
    rd_t  rdq[$];
    bit   ovf_exp;
    int   tests;
    int   fails;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check outputs against the model, update model.
    task automatic step(input logic req, input logic rw, input logic [AW-1:0] a,
                        input logic [31:0] wd, input logic rdy, input logic [31:0] mrd);
        rd_t         r;
        ent_t        e;
        bit          pop;
        bit          drop;
        logic        hit;
        logic [31:0] fd;
        @(negedge CLK);
        RST    = 1'b0;
        DREQ   = req;
        DRW    = rw;
        DADDR  = a;
        DWDATA = wd;
        MWRDY  = rdy;
        MRDATA = mrd;
        #1;
        if (rdq.size() != 0) begin
            r = rdq.pop_front();
            if (r.v) chk("drdata", DRDATA, r.hit ? r.d : mrd);
            else     chk("drdata_idle", DRDATA, 32'h0);
        end else begin
            chk("drdata_idle", DRDATA, 32'h0);
        end
        chk("mwe", {31'h0, MWE}, {31'h0, model.size() != 0});
        if (model.size() != 0) begin
            chk("mwaddr", {2'b0, MWADDR}, {2'b0, model[0].a});
            chk("mwdata", MWDATA, model[0].d);
        end
        chk("full", {31'h0, FULL}, {31'h0, model.size() == DEPTH});
        chk("ovf", {31'h0, OVF}, {31'h0, ovf_exp});
        chk("mre", {31'h0, MRE}, {31'h0, req && !rw});
        if (req && !rw) chk("mraddr", {2'b0, MRADDR}, {2'b0, a});

        hit = 1'b0;
        fd  = '0;
        foreach (model[i]) begin
            if (model[i].a == a) begin
                hit = 1'b1;
                fd  = model[i].d;
            end
        end
        r.v   = req && !rw;
        r.hit = hit;
        r.d   = fd;
        rdq.push_back(r);

        pop  = (model.size() != 0) && rdy;
        drop = req && rw && (model.size() == DEPTH) && !pop;
        if (drop) ovf_exp = 1'b1;
        if (pop) void'(model.pop_front());
        if (req && rw && !drop) begin
            e.a = a;
            e.d = wd;
            model.push_back(e);
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, '0, '0, rdy, 32'hFACE0000);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST   = 1'b1;
        DREQ  = 1'b0;
        MWRDY = 1'b1;
        #1;
        chk("rst_mwe", {31'h0, MWE}, 32'h0);
        chk("rst_full", {31'h0, FULL}, 32'h0);
        chk("rst_ovf", {31'h0, OVF}, 32'h0);
        chk("rst_drdata", DRDATA, 32'h0);
        model.delete();
        rdq.delete();
        ovf_exp = 1'b0;
        @(negedge CLK);
        chk("rst_hold_mwe", {31'h0, MWE}, 32'h0);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        ovf_exp = 1'b0;

        #1;
        chk("por_mwe", {31'h0, MWE}, 32'h0);
        chk("por_full", {31'h0, FULL}, 32'h0);
        chk("por_drdata", DRDATA, 32'h0);
        do_reset();

        // Single store drains the cycle after it is issued.
        step(1'b1, 1'b1, 30'h10, 32'h11111111, 1'b1, '0);
        idle(1'b1);
        idle(1'b1);

        // Youngest-match forwarding beats both older entry and memory data.
        step(1'b1, 1'b1, 30'h20, 32'hAAAA0000, 1'b0, '0);
        step(1'b1, 1'b1, 30'h20, 32'hBBBB0000, 1'b0, '0);
        step(1'b1, 1'b0, 30'h20, '0, 1'b0, '0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 32'hDEADBEEF);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Miss returns memory data, then an idle cycle returns zero.
        step(1'b1, 1'b0, 30'h55, '0, 1'b1, '0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 32'h12345678);
        idle(1'b1);

        // Fill, overflow, then drain in order with OVF sticky.
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, AW'(32'h100 + i), 32'hC0DE0000 + i, 1'b0, '0);
        idle(1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Store into a full buffer while the head drains is accepted.
        do_reset();
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, AW'(32'h200 + i), 32'h5A5A0000 + i, 1'b0, '0);
        step(1'b1, 1'b1, 30'h204, 32'h5A5A0004, 1'b1, '0);
        idle(1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Load of the head entry while it pops, then back-to-back loads.
        step(1'b1, 1'b1, 30'h300, 32'h30000000, 1'b0, '0);
        step(1'b1, 1'b1, 30'h301, 32'h30000001, 1'b0, '0);
        step(1'b1, 1'b0, 30'h300, '0, 1'b1, '0);
        step(1'b1, 1'b0, 30'h301, '0, 1'b1, 32'h0BAD0001);
        step(1'b1, 1'b0, 30'h302, '0, 1'b1, 32'h0BAD0002);
        step(1'b1, 1'b0, 30'h300, '0, 1'b1, 32'h0BAD0003);
        step(1'b0, 1'b0, '0, '0, 1'b1, 32'h0BAD0004);
        idle(1'b1);

        // Randomised mix over a small address space exercises pointer wrap.
        for (int k = 0; k < 150; k++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 3) + 32'h40), $urandom,
                 1'($urandom_range(0, 3) != 0), $urandom);
        for (int i = 0; i < 6; i++) idle(1'b1);

        // Reset mid-drain discards entries; a load in the release cycle completes.
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, AW'(32'h400 + i), 32'h77770000 + i, 1'b0, '0);
        do_reset();
        step(1'b1, 1'b0, 30'h400, '0, 1'b1, '0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 32'h99887766);
        idle(1'b1);
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
